// File: rtl/gb_pal_pkg.sv
// -----------------------------------------------------------------------------
// gb_pal_pkg
// Shared definitions for the Game Boy palette unit:
//   - CPU register window offsets (BCPS..OBP1)
//   - reset values of the DMG shade registers
//   - pix_t: pixel fields handed over by the PPU
//   - COLOR_W: width of the LCD pixel word
//   - dmg_shade(): 2-bit shade lookup in a BGP/OBP-style register
// -----------------------------------------------------------------------------
package gb_pal_pkg;

  localparam logic [2:0] A_BCPS = 3'd0;
  localparam logic [2:0] A_BCPD = 3'd1;
  localparam logic [2:0] A_OCPS = 3'd2;
  localparam logic [2:0] A_OCPD = 3'd3;
  localparam logic [2:0] A_BGP  = 3'd4;
  localparam logic [2:0] A_OBP0 = 3'd5;
  localparam logic [2:0] A_OBP1 = 3'd6;

  localparam logic [7:0] BGP_RST = 8'hFC;
  localparam logic [7:0] OBP_RST = 8'hFF;

  localparam int COLOR_W = 15;

  typedef struct packed {
    logic       obj;
    logic [2:0] pal;
    logic [1:0] idx;
  } pix_t;

  // Shade for colour index idx is the 2-bit field at bit position 2*idx.
  function automatic logic [1:0] dmg_shade(input logic [7:0] r, input logic [1:0] idx);
    logic [1:0] s;
    case (idx)
      2'd0:    s = r[1:0];
      2'd1:    s = r[3:2];
      2'd2:    s = r[5:4];
      default: s = r[7:6];
    endcase
    return s;
  endfunction

endpackage

// File: rtl/gb_pal_ram.sv
// -----------------------------------------------------------------------------
// gb_pal_ram
// One CGB palette RAM: ENTRIES x 16-bit colours held as two byte banks
// (lo = even byte address, hi = odd byte address).
// Ports:
//   clk_sys, ce_cpu   clock and clock enable (writes and pixel reads advance on ce)
//   cpu_we            byte write strobe (already qualified by ce/sel/lock upstream)
//   cpu_addr          byte address {entry, hi}
//   cpu_di / cpu_do   CPU write data / combinational read data
//   pix_addr          colour entry {pal, idx} for the pixel lookup
//   pix_do            registered colour {hi[6:0], lo}; bit 15 is never displayed
// A write and a pixel lookup of the same entry in one ce period return the
// old contents on pix_do (read-first).
// -----------------------------------------------------------------------------
module gb_pal_ram
  import gb_pal_pkg::*;
#(
  parameter  int ENTRIES = 32,
  localparam int AW      = $clog2(ENTRIES)
) (
  input  logic               clk_sys,
  input  logic               ce_cpu,
  input  logic               cpu_we,
  input  logic [AW:0]        cpu_addr,
  input  logic [7:0]         cpu_di,
  output logic [7:0]         cpu_do,
  input  logic [AW-1:0]      pix_addr,
  output logic [COLOR_W-1:0] pix_do
);

  logic [7:0]         lo_mem [ENTRIES];
  logic [7:0]         hi_mem [ENTRIES];
  logic [COLOR_W-1:0] pix_do_q;

  always_ff @(posedge clk_sys) begin
    if (ce_cpu) begin
      if (cpu_we) begin
        if (cpu_addr[0]) hi_mem[cpu_addr[AW:1]] <= cpu_di;
        else             lo_mem[cpu_addr[AW:1]] <= cpu_di;
      end
      pix_do_q <= {hi_mem[pix_addr][6:0], lo_mem[pix_addr]};
    end
  end

  assign cpu_do = cpu_addr[0] ? hi_mem[cpu_addr[AW:1]] : lo_mem[cpu_addr[AW:1]];
  assign pix_do = pix_do_q;

endmodule

// File: rtl/gb_palette_unit.sv
// -----------------------------------------------------------------------------
// gb_palette_unit
// Maps PPU pixel indices to the 15-bit LCD pixel word. Owns the CGB BG/OBJ
// palette RAMs (BCPS/BCPD/OCPS/OCPD) and the DMG BGP/OBP0/OBP1 registers.
// Pixels take two ce_cpu strobes from pix_valid to lcd_clkena.
// Ports:
//   clk_sys, reset_n (sync, active-low), ce_cpu (clock enable)
//   isGBC             1 = CGB colour output, 0 = DMG 2-bit shade
//   pal_lock          PPU mode 3; blocks CPU palette RAM access
//   cpu_sel/addr/wr/di/do   palette register window
//   pix_valid/obj/pal/idx   PPU pixel
//   lcd_data, lcd_clkena    pixel word and strobe to the LCD stage
// Build option: define GB_PAL_LOCK_EN to make pal_lock block palette RAM
// writes and force locked data reads to 8'hFF; otherwise pal_lock is ignored.
// -----------------------------------------------------------------------------
module gb_palette_unit
  import gb_pal_pkg::*;
#(
  parameter int PAL_ENTRIES = 32,
  parameter int LATENCY     = 2
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               ce_cpu,
  input  logic               isGBC,
  input  logic               pal_lock,
  input  logic               cpu_sel,
  input  logic [2:0]         cpu_addr,
  input  logic               cpu_wr,
  input  logic [7:0]         cpu_di,
  output logic [7:0]         cpu_do,
  input  logic               pix_valid,
  input  logic               pix_obj,
  input  logic [2:0]         pix_pal,
  input  logic [1:0]         pix_idx,
  output logic [COLOR_W-1:0] lcd_data,
  output logic               lcd_clkena
);

  localparam int AW = $clog2(PAL_ENTRIES);
  localparam int LATENCY_INFO = LATENCY;

  // Index registers: bit 6 = auto-increment, bits 5:0 = byte address.
  logic [6:0] bcps_q, bcps_d;
  logic [6:0] ocps_q, ocps_d;
  logic [7:0] bgp_q,  bgp_d;
  logic [7:0] obp0_q, obp0_d;
  logic [7:0] obp1_q, obp1_d;

  logic               vld_p1_q;
  logic               obj_p1_q;
  logic               gbc_p1_q;
  logic [1:0]         shade_p1_q;
  logic               lcd_clkena_q;
  logic [COLOR_W-1:0] lcd_data_q, lcd_data_d;

  logic               wr_en, lock_eff, bg_we, obj_we;
  logic [7:0]         bg_cpu_rd, obj_cpu_rd;
  logic [COLOR_W-1:0] bg_pix_rd, obj_pix_rd;
  pix_t               pix_in;
  logic [1:0]         shade_in;

`ifdef GB_PAL_LOCK_EN
  assign lock_eff = pal_lock;
`else
  logic unused_lock;
  assign unused_lock = pal_lock ^ (LATENCY_INFO != 0);
  assign lock_eff    = 1'b0;
`endif

  assign wr_en  = ce_cpu & cpu_sel & cpu_wr;
  assign bg_we  = wr_en & (cpu_addr == A_BCPD) & ~lock_eff;
  assign obj_we = wr_en & (cpu_addr == A_OCPD) & ~lock_eff;

  // Register next state; data-port writes advance the index even when locked.
  always_comb begin
    bcps_d = bcps_q;
    ocps_d = ocps_q;
    bgp_d  = bgp_q;
    obp0_d = obp0_q;
    obp1_d = obp1_q;
    if (wr_en) begin
      case (cpu_addr)
        A_BCPS:  bcps_d = {cpu_di[7], cpu_di[5:0]};
        A_BCPD:  if (bcps_q[6]) bcps_d[5:0] = bcps_q[5:0] + 6'd1;
        A_OCPS:  ocps_d = {cpu_di[7], cpu_di[5:0]};
        A_OCPD:  if (ocps_q[6]) ocps_d[5:0] = ocps_q[5:0] + 6'd1;
        A_BGP:   bgp_d  = cpu_di;
        A_OBP0:  obp0_d = cpu_di;
        A_OBP1:  obp1_d = cpu_di;
        default: ;
      endcase
    end
  end

  always_comb begin
    cpu_do = 8'hFF;
    case (cpu_addr)
      A_BCPS:  cpu_do = {bcps_q[6], 1'b1, bcps_q[5:0]};
      A_BCPD:  cpu_do = lock_eff ? 8'hFF : bg_cpu_rd;
      A_OCPS:  cpu_do = {ocps_q[6], 1'b1, ocps_q[5:0]};
      A_OCPD:  cpu_do = lock_eff ? 8'hFF : obj_cpu_rd;
      A_BGP:   cpu_do = bgp_q;
      A_OBP0:  cpu_do = obp0_q;
      A_OBP1:  cpu_do = obp1_q;
      default: cpu_do = 8'hFF;
    endcase
  end

  // ---- stage 1: capture pixel, DMG shade lookup, issue RAM read ----
  assign pix_in   = '{obj: pix_obj, pal: pix_pal, idx: pix_idx};
  assign shade_in = dmg_shade(pix_in.obj ? (pix_in.pal[0] ? obp1_q : obp0_q) : bgp_q,
                              pix_in.idx);

  gb_pal_ram #(.ENTRIES(PAL_ENTRIES)) u_bg_ram (
    .clk_sys  (clk_sys),
    .ce_cpu   (ce_cpu),
    .cpu_we   (bg_we),
    .cpu_addr (bcps_q[AW:0]),
    .cpu_di   (cpu_di),
    .cpu_do   (bg_cpu_rd),
    .pix_addr ({pix_in.pal, pix_in.idx}),
    .pix_do   (bg_pix_rd)
  );

  gb_pal_ram #(.ENTRIES(PAL_ENTRIES)) u_obj_ram (
    .clk_sys  (clk_sys),
    .ce_cpu   (ce_cpu),
    .cpu_we   (obj_we),
    .cpu_addr (ocps_q[AW:0]),
    .cpu_di   (cpu_di),
    .cpu_do   (obj_cpu_rd),
    .pix_addr ({pix_in.pal, pix_in.idx}),
    .pix_do   (obj_pix_rd)
  );

  always_ff @(posedge clk_sys) begin
    if (ce_cpu && pix_valid) begin
      obj_p1_q   <= pix_in.obj;
      gbc_p1_q   <= isGBC;
      shade_p1_q <= shade_in;
    end
  end

  // ---- stage 2: select colour or shade into the LCD word ----
  assign lcd_data_d = gbc_p1_q ? (obj_p1_q ? obj_pix_rd : bg_pix_rd)
                               : {{(COLOR_W-2){1'b0}}, shade_p1_q};

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      bcps_q       <= '0;
      ocps_q       <= '0;
      bgp_q        <= BGP_RST;
      obp0_q       <= OBP_RST;
      obp1_q       <= OBP_RST;
      vld_p1_q     <= 1'b0;
      lcd_clkena_q <= 1'b0;
      lcd_data_q   <= '0;
    end else if (ce_cpu) begin
      bcps_q       <= bcps_d;
      ocps_q       <= ocps_d;
      bgp_q        <= bgp_d;
      obp0_q       <= obp0_d;
      obp1_q       <= obp1_d;
      vld_p1_q     <= pix_valid;
      lcd_clkena_q <= vld_p1_q;
      if (vld_p1_q) lcd_data_q <= lcd_data_d;
    end
  end

  assign lcd_data   = lcd_data_q;
  assign lcd_clkena = lcd_clkena_q;

endmodule

// File: doc/gb_palette_unit.md
Name: gb_palette_unit

Overview:
- Upstream of the LCD scan-out buffer.
- Converts PPU pixel indices into the 15-bit pixel word and write strobe that the LCD stage consumes (`lcd_data`, `lcd_clkena`). The LCD stage samples these on `ce_cpu`.
- Owns the CGB BG/OBJ palette RAMs (FF68-FF6B) with index auto-increment and mode-3 CPU lockout.
- In DMG mode, owns BGP/OBP0/OBP1 shade mapping and emits a 2-bit shade.

Parameters:
- `PAL_ENTRIES`, 32: colours per RAM (8 palettes x 4 colours).
- `LATENCY`, 2: `ce_cpu` strobes from pixel accepted to `lcd_clkena`; fixed, informational only.

Ports:
- `clk_sys` in 1: system clock, 33.554432 MHz.
- `reset_n` in 1: synchronous, active-low reset.
- `ce_cpu` in 1: 4.194304 MHz clock enable; the pipeline and register writes advance only on it.
- `isGBC` in 1: selects CGB colour path (1) or DMG shade path (0).
- `pal_lock` in 1: PPU in mode 3; blocks CPU palette RAM access.
- `cpu_sel` in 1: palette register window selected.
- `cpu_addr` in 3: 0=BCPS 1=BCPD 2=OCPS 3=OCPD 4=BGP 5=OBP0 6=OBP1.
- `cpu_wr` in 1: write strobe, qualified by `ce_cpu` and `cpu_sel`.
- `cpu_di` in 8: write data.
- `cpu_do` out 8: read data, combinational from registers and the RAM read port.
- `pix_valid` in 1: PPU presents a pixel this `ce_cpu`.
- `pix_obj` in 1: pixel comes from an object (1) or BG/window (0).
- `pix_pal` in 3: CGB palette number; DMG uses bit 0 to pick OBP0/OBP1.
- `pix_idx` in 2: colour index.
- `lcd_data` out 15: {B5,G5,R5} for CGB; {13'd0, shade} for DMG.
- `lcd_clkena` out 1: one pixel valid for the LCD stage.

Behaviour:
- Reset (`reset_n`=0 at a `clk_sys` edge):
  - BCPS/OCPS = 0 (auto-inc off, index 0).
  - BGP = 8'hFC; OBP0 = OBP1 = 8'hFF.
  - Pipeline valid bits, `lcd_clkena` and `lcd_data` go to 0.
  - RAM contents are not reset.
  - Reset mid-stream drops in-flight pixels; no `lcd_clkena` fires until a new `pix_valid` has travelled the full latency.
- Palette RAM storage: each RAM is two byte banks (even = low byte, odd = high byte) of 32 entries.
  - Byte address = {pal[2:0], idx[1:0], hi}.
- Index registers (BCPS/OCPS): bit 7 = auto-inc, bits 5:0 = byte address.
  - Reads return {ai, 1'b1, addr}.
- Data write (BCPD/OCPD):
  - If `pal_lock`=0: write `cpu_di` to RAM[addr].
  - Regardless of lock: if ai=1, addr <= addr+1, wrapping 63 -> 0. Bit 7 is preserved.
- Data read: returns RAM[addr] when unlocked, 8'hFF when locked. Reads never increment.
- BGP/OBP0/OBP1 are plain read/write in both modes. An unselected `cpu_addr` (5'd7) reads 8'hFF.
- Pipeline, advancing on `ce_cpu` only:
  - Stage 1 registers the pixel fields and issues the 16-bit read from the BG or OBJ RAM.
  - Stage 2 registers the result into `lcd_data` and asserts `lcd_clkena` for exactly one `ce_cpu` period.
  - CGB colour = {hi[6:0], lo}; bit 15 is discarded.
  - DMG shade = (reg >> 2*idx) & 3, where reg is BGP, or OBP0/OBP1 selected by `pix_pal[0]`.
  - DMG OBJ pixels with idx 0 still pass through; the PPU owns transparency.
- Back-to-back: one pixel per `ce_cpu` sustained, no bubbles. `pix_valid`=0 produces `lcd_clkena`=0 two strobes later.
- Same-cycle CPU write and pixel lookup of the same entry: the lookup returns the old value (read-first).
- CPU writes to BGP/OBP affect pixels entering stage 1 on the following `ce_cpu` or later.
- `isGBC` is sampled per pixel at stage 1.

Optional Feature:
- Macro: `GB_PAL_LOCK_EN`.
- Defined: `pal_lock` enforces the mode-3 write block and the 8'hFF read value, as above.
- Undefined: `pal_lock` is ignored; CPU accesses always succeed. Auto-increment is unchanged.

Decomposition:
- Package `gb_pal_pkg`:
  - `cpu_addr` constants (BCPS..OBP1).
  - Reset values for BGP/OBP.
  - `pix_t` struct {obj, pal[2:0], idx[1:0]}.
  - Colour width constant 15.
- Sub-module `gb_pal_ram`: 32x16 dual-port RAM with per-byte write enable, CPU port for write/read, pixel read port with registered output. Instantiated twice (BG, OBJ).

Test Plan:
- Auto-increment writes, CGB, unlocked:
  - Stimulus: BCPS=8'h80, then BCPD writes 8'h1F, 8'h00 (index 0).
  - Required: BCPS reads 8'hC2.
  - Stimulus: pixel (BG, pal 0, idx 0).
  - Required: `lcd_data`=15'h001F with `lcd_clkena` on the 2nd `ce_cpu` after `pix_valid`.
- Index wrap:
  - Stimulus: OCPS=8'hBF, then OCPD write 8'h55.
  - Required: OBJ byte 63 = 8'h55; OCPS reads 8'hC0.
- Lock, macro defined:
  - Stimulus: `pal_lock`=1, BCPS=8'h84, BCPD write 8'hAA.
  - Required: RAM byte 4 unchanged; BCPS reads 8'hC5; BCPD read returns 8'hFF.
- DMG shade mapping:
  - Stimulus: `isGBC`=0, BGP=8'hE4; idx 0,1,2,3 back-to-back.
  - Required: `lcd_data` 0,1,2,3 on four consecutive `ce_cpu`.
  - Stimulus: OBP1=8'h1B, obj pixel, pal[0]=1, idx 0.
  - Required: shade 3.
- Read-first collision:
  - Stimulus: entry BG pal 2 idx 1 = 15'h7C00; in the same `ce_cpu`, write its low byte 8'hFF and present that pixel.
  - Required: output 15'h7C00; the next lookup gives 15'h7CFF.
- Reset mid-stream:
  - Stimulus: `reset_n` low for one cycle with two pixels in flight.
  - Required: no `lcd_clkena` for the next 2 `ce_cpu`; BGP reads 8'hFC.
